usb_tx_serializer: RTL and testbench

- Parametrised USB full-speed transmit serializer; successor to the single-bit TX PHY state machine.
- Accepts DATA_W-bit words over a UTMI-style TxValid/TxReady handshake.
- Emits SYNC, LSB-first data with bit stuffing and NRZI encoding, then EOP.
- Sits between the link-layer TX buffer and the differential pad drivers (txdp/txdn/txoe).

---
 rtl/usb_phy_pkg.sv | 26 ++
 rtl/usb_tx_serializer_if.sv | 22 ++
 rtl/usb_tx_serializer_nrzi_stuff.sv | 55 +++++
 rtl/usb_tx_serializer.sv | 153 +++++++++++++++
 tb/tb_usb_tx_serializer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/usb_phy_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
package usb_phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOP,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  // Bus line state as {dp,dn}
  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam int unsigned STUFF_LEN_DEF = 6;

  // NRZI transition: J <-> K
  function automatic line_t nrzi_toggle(input line_t cur);
    return (cur == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// UTMI-style transmit handshake between the link-layer buffer and the serializer.
interface usb_tx_serializer_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] DataOut_i;
  logic              TxValid_i;
  logic              TxReady_o;

  modport master (
    output DataOut_i,
    output TxValid_i,
    input  TxReady_o
  );

  modport slave (
    input  DataOut_i,
    input  TxValid_i,
    output TxReady_o
  );

endinterface

// File: rtl/usb_tx_serializer_nrzi_stuff.sv
// Bit-stuff counter and NRZI line register for the transmit serializer.
// When valid is set on a bit time, either the requested bit or a pending
// stuff 0 is put on the line; se0/force_j override the line during EOP.
module usb_tx_nrzi_stuff
  import usb_phy_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  fs_ce,
  input  logic  init,
  input  logic  valid,
  input  logic  bit_in,
  input  logic  se0,
  input  logic  force_j,
  output logic  stuff_req,
  output line_t line
);

  localparam int unsigned CW = (STUFF_LEN < 1) ? 1 : $clog2(STUFF_LEN + 1);

  logic [CW-1:0] ones_cnt;
  line_t         line_q;
  logic          emit_one;

  assign stuff_req = (ones_cnt == CW'(STUFF_LEN));
  assign emit_one  = bit_in & ~stuff_req;
  assign line      = line_q;

  // Track consecutive emitted ones and drive the NRZI-encoded line level
  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_cnt <= '0;
      line_q   <= LINE_J;
    end else if (init) begin
      ones_cnt <= '0;
      line_q   <= LINE_J;
    end else if (fs_ce) begin
      if (valid) begin
        if (emit_one) begin
          ones_cnt <= ones_cnt + 1'b1;
        end else begin
          ones_cnt <= '0;
          line_q   <= nrzi_toggle(line_q);
        end
      end else if (se0) begin
        line_q <= LINE_SE0;
      end else if (force_j) begin
        line_q <= LINE_J;
      end
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: SYNC, LSB-first data with bit
// stuffing and NRZI, then EOP, paced by the fs_ce bit-time strobe.
module usb_tx_serializer
  import usb_phy_pkg::*;
#(
  parameter int unsigned       DATA_W       = 8,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = {1'b1, {(DATA_W-1){1'b0}}},
  parameter int unsigned       STUFF_LEN    = STUFF_LEN_DEF,
  parameter int unsigned       EOP_SE0_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fs_ce,
  usb_tx_serializer_if.slave   utmi,
  output logic                 txdp,
  output logic                 txdn,
  output logic                 txoe
);

  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [2:0]    SE0_LAST = 3'(EOP_SE0_BITS);

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] hold_reg, hold_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [2:0]        eop_cnt, eop_cnt_n;
  logic              txoe_q, txoe_n;
  logic              ready_q, ready_n;

  logic              ns_init;
  logic              ns_valid;
  logic              ns_se0;
  logic              ns_force_j;
  logic              stuff_req;
  line_t             line;

  usb_tx_nrzi_stuff #(
    .STUFF_LEN (STUFF_LEN)
  ) u_nrzi_stuff (
    .clk       (clk),
    .rst       (rst),
    .fs_ce     (fs_ce),
    .init      (ns_init),
    .valid     (ns_valid),
    .bit_in    (hold_reg[0]),
    .se0       (ns_se0),
    .force_j   (ns_force_j),
    .stuff_req (stuff_req),
    .line      (line)
  );

  assign txdp           = line[1];
  assign txdn           = line[0];
  assign txoe           = txoe_q;
  assign utmi.TxReady_o = ready_q;

  // State, shift register, counters and registered handshake/enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      hold_reg <= '0;
      bit_cnt  <= '0;
      eop_cnt  <= '0;
      txoe_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      hold_reg <= hold_n;
      bit_cnt  <= bit_cnt_n;
      eop_cnt  <= eop_cnt_n;
      txoe_q   <= txoe_n;
      ready_q  <= ready_n;
    end
  end

  // Next-state logic and per-bit-time control of the stuff/NRZI stage.
  // A stuff bit still owed after the last data bit is sent from EOP_SE0
  // before the first SE0, so no extra state is needed for it.
  always_comb begin
    state_n    = state;
    hold_n     = hold_reg;
    bit_cnt_n  = bit_cnt;
    eop_cnt_n  = eop_cnt;
    txoe_n     = txoe_q;
    ready_n    = 1'b0;
    ns_init    = 1'b0;
    ns_valid   = 1'b0;
    ns_se0     = 1'b0;
    ns_force_j = 1'b0;

    unique case (state)
      IDLE: begin
        if (utmi.TxValid_i) begin
          hold_n    = SYNC_PATTERN;
          bit_cnt_n = '0;
          eop_cnt_n = '0;
          ns_init   = 1'b1;
          state_n   = SOP;
        end
      end

      SOP, DATA: begin
        if (fs_ce) begin
          txoe_n   = 1'b1;
          ns_valid = 1'b1;
          if (!stuff_req) begin
            hold_n = hold_reg >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_n = '0;
              if (utmi.TxValid_i) begin
                hold_n  = utmi.DataOut_i;
                ready_n = 1'b1;
                state_n = DATA;
              end else begin
                eop_cnt_n = '0;
                state_n   = EOP_SE0;
              end
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end
        end
      end

      EOP_SE0: begin
        if (fs_ce) begin
          if (stuff_req) begin
            ns_valid = 1'b1;
          end else if (eop_cnt < SE0_LAST) begin
            ns_se0    = 1'b1;
            eop_cnt_n = eop_cnt + 1'b1;
          end else begin
            ns_force_j = 1'b1;
            state_n    = EOP_J;
          end
        end
      end

      EOP_J: begin
        if (fs_ce) begin
          txoe_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: each packet's expected bus
// activity is computed bit-by-bit from the line-coding rules and compared
// on every clock.
module tb_usb_tx_serializer;
  import usb_phy_pkg::*;

  localparam int DW = 8;
  localparam int SL = 6;
  localparam int EB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fs_ce = 1'b0;
  logic txdp, txdn, txoe;

  usb_tx_serializer_if #(.DATA_W(DW)) bus ();

  usb_tx_serializer #(
    .DATA_W       (DW),
    .STUFF_LEN    (SL),
    .EOP_SE0_BITS (EB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .fs_ce (fs_ce),
    .utmi  (bus),
    .txdp  (txdp),
    .txdn  (txdn),
    .txoe  (txoe)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // entries are {ready, txoe, dp, dn} for one bit time
  logic [3:0]    exp_q[$];
  logic [DW-1:0] pkt_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_exp();
    logic [DW-1:0] v;
    int            ones;
    logic          jl;
    logic          rdy;
    exp_q.delete();
    ones = 0;
    jl   = 1'b1;
    for (int s = 0; s <= pkt_q.size(); s++) begin
      if (s == 0) v = 8'h80;
      else        v = pkt_q[s-1];
      for (int b = 0; b < DW; b++) begin
        if (ones == SL) begin
          jl   = ~jl;
          ones = 0;
          exp_q.push_back({1'b0, 1'b1, jl, ~jl});
        end
        if (v[b]) ones++;
        else begin
          ones = 0;
          jl   = ~jl;
        end
        rdy = (b == DW - 1) && (s < pkt_q.size());
        exp_q.push_back({rdy, 1'b1, jl, ~jl});
      end
    end
    if (ones == SL) begin
      jl = ~jl;
      exp_q.push_back({1'b0, 1'b1, jl, ~jl});
    end
    repeat (EB) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0010);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_bus"}, {txoe, txdp, txdn}, 3'b010);
    check_eq({tag, "_rdy"}, bus.TxReady_o, 1'b0);
  endtask

  task automatic run_pkt(input int period, input int stall_at, input int abort_at, input bit glitch);
    int         idx, cyc, wi, stall_left, pulses;
    logic [3:0] prev, e;
    logic       fs;
    build_exp();
    @(negedge clk);
    bus.TxValid_i = 1'b1;
    bus.DataOut_i = pkt_q[0];
    fs_ce = 1'b0;
    @(posedge clk); #1;
    check_idle("start");
    prev = 4'b0010; idx = 0; cyc = 0; wi = 0; stall_left = 50; pulses = 0;
    while (idx < int'(exp_q.size())) begin
      @(negedge clk);
      if (idx == abort_at) begin
        rst   = 1'b0;
        fs_ce = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check_idle("abort");
        @(negedge clk);
        rst = 1'b1;
        bus.TxValid_i = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check_idle("post_abort");
        end
        return;
      end
      fs = ((cyc % period) == period - 1);
      cyc++;
      if (idx == stall_at && stall_left > 0) begin
        fs = 1'b0;
        stall_left--;
      end
      fs_ce = fs;
      if (fs)          bus.TxValid_i = (wi < int'(pkt_q.size()));
      else if (glitch) bus.TxValid_i = 1'($urandom_range(0, 1));
      if (wi < int'(pkt_q.size())) bus.DataOut_i = pkt_q[wi];
      else                         bus.DataOut_i = DW'($urandom);
      @(posedge clk); #1;
      e = fs ? exp_q[idx] : {1'b0, prev[2:0]};
      check_eq("bus", {txoe, txdp, txdn}, e[2:0]);
      check_eq("ready", bus.TxReady_o, e[3]);
      if (bus.TxReady_o) pulses++;
      if (fs) begin
        if (exp_q[idx][3]) wi++;
        prev = exp_q[idx];
        idx++;
      end
    end
    @(negedge clk);
    bus.TxValid_i = 1'b0;
    fs_ce = 1'b0;
    check_eq("pulses", pulses, pkt_q.size());
    @(posedge clk); #1;
    check_idle("after_pkt");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.TxValid_i = 1'b1;
    bus.DataOut_i = '0;
    rst   = 1'b0;
    fs_ce = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_idle("reset");
    end
    @(negedge clk);
    rst = 1'b1;
    bus.TxValid_i = 1'b0;
    fs_ce = 1'b0;
    @(posedge clk); #1;
    check_idle("rel");

    pkt_q = '{8'h00};
    run_pkt(4, -1, -1, 1'b0);

    pkt_q = '{8'hFF};
    run_pkt(4, -1, -1, 1'b0);

    pkt_q = '{8'hA5, 8'h3C, 8'h0F};
    run_pkt(4, -1, -1, 1'b0);

    pkt_q = '{8'h5A, 8'hC3, 8'h77};
    run_pkt(4, -1, 19, 1'b0);

    pkt_q = '{8'hA5, 8'h3C, 8'h0F};
    run_pkt(3, -1, -1, 1'b0);

    pkt_q = '{8'h12, 8'hFE, 8'h81};
    run_pkt(4, 12, -1, 1'b0);

    for (int p = 0; p < 8; p++) begin
      int n;
      pkt_q.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) pkt_q.push_back(8'hFF);
        else                           pkt_q.push_back(DW'($urandom));
      end
      run_pkt($urandom_range(1, 5), -1, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
